// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_pkg
// Description : Shared types and encodings for the multicycle RV32I control
//               unit: FSM states, ALU codes, opcodes, mux selects and the
//               bundle of registered control fields.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_unit_pkg;

    // Main FSM state encoding; also exported on state_dbg
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // ALU operation codes; low 3 bits of the base ops match the legacy codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Supported opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_PC      = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC   = 2'b01;
    localparam logic [1:0] SRC_A_RS1     = 2'b10;
    localparam logic [1:0] SRC_B_RS2     = 2'b00;
    localparam logic [1:0] SRC_B_IMM     = 2'b01;
    localparam logic [1:0] SRC_B_FOUR    = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;

    // Registered control fields; strobes are the ungated base values
    typedef struct packed {
        logic       ir_write;
        logic       pc_fetch;
        logic       pc_jump;
        logic       branch;
        logic       branch_inv;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [3:0] alu_control;
    } ctrl_t;

    // All strobes off, ALU adding PC + rs2
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c             = '0;
        c.alu_control = ALU_ADD;
        c.alu_src_a   = SRC_A_PC;
        c.alu_src_b   = SRC_B_RS2;
        c.result_src  = RES_ALUOUT;
        c.imm_src     = IMM_I;
        return c;
    endfunction

    // FETCH: read instruction at PC and compute PC + 4 into the PC
    function automatic ctrl_t ctrl_fetch();
        ctrl_t c;
        c            = ctrl_idle();
        c.ir_write   = 1'b1;
        c.pc_fetch   = 1'b1;
        c.alu_src_b  = SRC_B_FOUR;
        c.result_src = RES_ALURESULT;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Instruction-field / status inputs and control outputs between
//               the multicycle datapath (master) and its control unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, illegal, state_dbg
    );

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, illegal, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/alu_decoder_ext.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder_ext
// Description : Combinational ALU decoder. Maps the operation class and the
//               funct fields to a 4-bit ALU code and flags decodes that need
//               an operation this build does not provide.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder_ext
    import multicycle_control_unit_pkg::*;
#(
    parameter int EXT_ALU = 1
) (
    input  logic [1:0] alu_op,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control,
    output logic       unsupported
);

    localparam logic EXT_OK = (EXT_ALU != 0);

    // Decode ALU code; extended ops are unsupported when EXT_ALU is 0
    always_comb begin
        alu_control = ALU_ADD;
        unsupported = 1'b0;
        case (alu_op)
            ALUOP_CMP: begin
                case (funct3)
                    3'b000, 3'b001: alu_control = ALU_SUB;
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: begin
                        alu_control = ALU_SLTU;
                        unsupported = ~EXT_OK;
                    end
                    default: unsupported = 1'b1;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can subtract; addi ignores bit 30
                    3'b000: alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        alu_control = ALU_SLL;
                        unsupported = ~EXT_OK;
                    end
                    3'b010: alu_control = ALU_SLT;
                    3'b011: begin
                        alu_control = ALU_SLTU;
                        unsupported = ~EXT_OK;
                    end
                    3'b100: begin
                        alu_control = ALU_XOR;
                        unsupported = ~EXT_OK;
                    end
                    3'b101: begin
                        alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                        unsupported = ~EXT_OK;
                    end
                    3'b110: alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: begin
                alu_control = ALU_ADD;
                unsupported = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Main FSM of the multicycle RV32I core. Sequences fetch,
//               decode, execute, memory and writeback; control fields are
//               registered from the next state, and only the write strobes
//               are gated by mem_ready, zero and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int EXT_ALU  = 1,
    parameter int WAIT_MEM = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.slave  bus
);

    state_t     state;
    state_t     nxt;
    ctrl_t      ctrl;
    ctrl_t      nxt_ctrl;
    logic       illegal_r;
    logic       mem_ok;
    logic       taken;
    logic [1:0] dec_alu_op;
    logic [3:0] dec_alu_control;
    logic       dec_unsupported;

    assign mem_ok = (WAIT_MEM == 0) ? 1'b1 : bus.mem_ready;
    assign taken  = bus.zero ^ ctrl.branch_inv;

    // Operation class for the decoder; only used while in DECODE
    always_comb begin
        case (bus.op)
            OP_RTYPE, OP_ITYPE: dec_alu_op = ALUOP_FUNCT;
            OP_BRANCH:          dec_alu_op = ALUOP_CMP;
            default:            dec_alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder_ext #(
        .EXT_ALU (EXT_ALU)
    ) u_alu_decoder (
        .alu_op      (dec_alu_op),
        .op5         (bus.op[5]),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_control (dec_alu_control),
        .unsupported (dec_unsupported)
    );

    // Next state and the control fields that go with it
    always_comb begin
        nxt      = state;
        nxt_ctrl = ctrl_idle();
        case (state)
            S_FETCH:    if (mem_ok) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = dec_unsupported ? S_TRAP : S_EXECR;
                    OP_ITYPE:          nxt = dec_unsupported ? S_TRAP : S_EXECI;
                    OP_BRANCH:         nxt = dec_unsupported ? S_TRAP : S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ok) nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: if (mem_ok) nxt = S_FETCH;
            S_EXECR,
            S_EXECI:    nxt = S_ALUWB;
            S_ALUWB,
            S_BRANCH:   nxt = S_FETCH;
            S_JAL:      nxt = S_ALUWB;
            default:    nxt = S_TRAP;
        endcase

        // Funct-dependent fields are captured on the DECODE exit edge,
        // while the IR still holds the decoded instruction
        case (nxt)
            S_FETCH:  nxt_ctrl = ctrl_fetch();
            S_DECODE: begin
                nxt_ctrl.alu_src_a = SRC_A_OLDPC;
                nxt_ctrl.alu_src_b = SRC_B_IMM;
                nxt_ctrl.imm_src   = IMM_B;
            end
            S_MEMADR: begin
                nxt_ctrl.alu_src_a = SRC_A_RS1;
                nxt_ctrl.alu_src_b = SRC_B_IMM;
                nxt_ctrl.imm_src   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD:  nxt_ctrl.adr_src = 1'b1;
            S_MEMWB: begin
                nxt_ctrl.result_src = RES_DATA;
                nxt_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                nxt_ctrl.adr_src   = 1'b1;
                nxt_ctrl.mem_write = 1'b1;
            end
            S_EXECR: begin
                nxt_ctrl.alu_src_a   = SRC_A_RS1;
                nxt_ctrl.alu_src_b   = SRC_B_RS2;
                nxt_ctrl.alu_control = dec_alu_control;
            end
            S_EXECI: begin
                nxt_ctrl.alu_src_a   = SRC_A_RS1;
                nxt_ctrl.alu_src_b   = SRC_B_IMM;
                nxt_ctrl.imm_src     = IMM_I;
                nxt_ctrl.alu_control = dec_alu_control;
            end
            S_ALUWB: begin
                nxt_ctrl.result_src = RES_ALUOUT;
                nxt_ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                nxt_ctrl.alu_src_a   = SRC_A_RS1;
                nxt_ctrl.alu_src_b   = SRC_B_RS2;
                nxt_ctrl.imm_src     = IMM_B;
                nxt_ctrl.alu_control = dec_alu_control;
                nxt_ctrl.branch      = 1'b1;
                // bne/blt/bltu take the branch on a nonzero compare result
                nxt_ctrl.branch_inv  = bus.funct3[0] ^ bus.funct3[2];
            end
            S_JAL: begin
                nxt_ctrl.alu_src_a  = SRC_A_OLDPC;
                nxt_ctrl.alu_src_b  = SRC_B_FOUR;
                nxt_ctrl.imm_src    = IMM_J;
                nxt_ctrl.result_src = RES_ALUOUT;
                nxt_ctrl.pc_jump    = 1'b1;
            end
            default:  nxt_ctrl = ctrl_idle();
        endcase
    end

    // State, registered control fields and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            ctrl      <= ctrl_fetch();
            illegal_r <= 1'b0;
        end else begin
            state <= nxt;
            ctrl  <= nxt_ctrl;
            if (nxt == S_TRAP) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Strobes are forced low while reset is asserted so no partial write leaks
    assign bus.pc_write    = rst_n & ((ctrl.pc_fetch & mem_ok) | ctrl.pc_jump |
                                      (ctrl.branch & taken));
    assign bus.ir_write    = rst_n & ctrl.ir_write & mem_ok;
    assign bus.mem_write   = rst_n & ctrl.mem_write;
    assign bus.reg_write   = rst_n & ctrl.reg_write;
    assign bus.adr_src     = ctrl.adr_src;
    assign bus.result_src  = ctrl.result_src;
    assign bus.alu_src_a   = ctrl.alu_src_a;
    assign bus.alu_src_b   = ctrl.alu_src_b;
    assign bus.imm_src     = ctrl.imm_src;
    assign bus.alu_control = ctrl.alu_control;
    assign bus.illegal     = illegal_r;
    assign bus.state_dbg   = state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Directed self-checking bench for the multicycle control unit.
//               Runs a full-ALU and a base-ALU instance side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_EXECI    = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [3:0] lw_states [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

    multicycle_control_unit_if bus_a ();
    multicycle_control_unit_if bus_b ();

    assign bus_a.op        = op;
    assign bus_a.funct3    = funct3;
    assign bus_a.funct7b5  = funct7b5;
    assign bus_a.zero      = zero;
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.op        = op;
    assign bus_b.funct3    = funct3;
    assign bus_b.funct7b5  = funct7b5;
    assign bus_b.zero      = zero;
    assign bus_b.mem_ready = mem_ready;

    multicycle_control_unit #(.EXT_ALU(1), .WAIT_MEM(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    multicycle_control_unit #(.EXT_ALU(0), .WAIT_MEM(1)) u_dut_base (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample point: just after the inactive (falling) edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op = OPC_LOAD; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_state",    bus_a.state_dbg, ST_FETCH);
        check("rst_illegal",  bus_a.illegal,   1'b0);
        check("rst_pc_write", bus_a.pc_write,  1'b0);
        check("rst_ir_write", bus_a.ir_write,  1'b0);

        // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("lw_state",     bus_a.state_dbg, lw_states[i]);
            check("lw_reg_write", bus_a.reg_write, (i == 4));
            if (i == 0) begin
                check("fetch_ir_write",  bus_a.ir_write,  1'b1);
                check("fetch_pc_write",  bus_a.pc_write,  1'b1);
                check("fetch_alu_src_b", bus_a.alu_src_b, 2'b10);
            end
            if (i == 4) check("lw_result_src", bus_a.result_src, 2'b01);
            step();
        end
        check("lw_done_state", bus_a.state_dbg, ST_FETCH);

        // sw with memory stalled 3 cycles in MEMWRITE
        set_instr(OPC_STORE, 3'b010, 1'b0);
        step();
        check("sw_decode",     bus_a.state_dbg, ST_DECODE);
        check("decode_imm_b",  bus_a.imm_src,   2'b10);
        step();
        check("sw_memadr",     bus_a.state_dbg, ST_MEMADR);
        check("sw_imm_s",      bus_a.imm_src,   2'b01);
        step();
        mem_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                mem_ready = 1'b1;
                #1;
            end
            check("sw_wait_state", bus_a.state_dbg, ST_MEMWRITE);
            check("sw_mem_write",  bus_a.mem_write, 1'b1);
            check("sw_adr_src",    bus_a.adr_src,   1'b1);
            if (k < 3) step();
        end
        step();
        check("sw_done_state",     bus_a.state_dbg, ST_FETCH);
        check("sw_done_mem_write", bus_a.mem_write, 1'b0);

        // R-type sub
        set_instr(OPC_RTYPE, 3'b000, 1'b1);
        step();
        step();
        check("sub_state", bus_a.state_dbg,   ST_EXECR);
        check("sub_alu",   bus_a.alu_control, 4'b0001);
        check("sub_src_a", bus_a.alu_src_a,   2'b10);
        step();
        check("sub_wb_state",     bus_a.state_dbg, ST_ALUWB);
        check("sub_wb_reg_write", bus_a.reg_write, 1'b1);
        step();

        // addi with bit 30 set still adds
        set_instr(OPC_ITYPE, 3'b000, 1'b1);
        step();
        step();
        check("addi_state", bus_a.state_dbg,   ST_EXECI);
        check("addi_alu",   bus_a.alu_control, 4'b0000);
        check("addi_src_b", bus_a.alu_src_b,   2'b01);
        step();
        step();

        // srai: SRA on full ALU, trap on base ALU
        set_instr(OPC_ITYPE, 3'b101, 1'b1);
        step();
        step();
        check("srai_state",      bus_a.state_dbg,   ST_EXECI);
        check("srai_alu",        bus_a.alu_control, 4'b1001);
        check("base_srai_state", bus_b.state_dbg,   ST_TRAP);
        check("base_illegal",    bus_b.illegal,     1'b1);
        check("full_illegal",    bus_a.illegal,     1'b0);
        step();
        check("base_trap_hold",  bus_b.state_dbg,   ST_TRAP);
        check("base_trap_regwr", bus_b.reg_write,   1'b0);
        step();

        // bne: taken on zero=0, not taken on zero=1
        zero = 1'b0;
        set_instr(OPC_BRANCH, 3'b001, 1'b0);
        step();
        step();
        check("bne_state",    bus_a.state_dbg,   ST_BRANCH);
        check("bne_alu",      bus_a.alu_control, 4'b0001);
        check("bne_taken",    bus_a.pc_write,    1'b1);
        zero = 1'b1;
        #1;
        check("bne_nottaken", bus_a.pc_write,    1'b0);
        step();
        check("bne_done",     bus_a.state_dbg,   ST_FETCH);

        // bge with zero=0 means rs1 < rs2: not taken
        zero = 1'b0;
        set_instr(OPC_BRANCH, 3'b101, 1'b0);
        step();
        step();
        check("bge_alu",      bus_a.alu_control, 4'b0101);
        check("bge_nottaken", bus_a.pc_write,    1'b0);
        step();

        // branch funct3=010 is illegal
        set_instr(OPC_BRANCH, 3'b010, 1'b0);
        step();
        step();
        check("br010_state",   bus_a.state_dbg, ST_TRAP);
        check("br010_illegal", bus_a.illegal,   1'b1);
        step();
        check("trap_hold",     bus_a.state_dbg, ST_TRAP);
        check("trap_pc_write", bus_a.pc_write,  1'b0);

        // Reset clears the trap asynchronously
        rst_n = 1'b0;
        #1;
        check("trap_rst_state",   bus_a.state_dbg, ST_FETCH);
        check("trap_rst_illegal", bus_a.illegal,   1'b0);
        step();
        rst_n = 1'b1;
        #1;

        // FETCH stalls until mem_ready
        mem_ready = 1'b0;
        #1;
        check("fetch_stall_ir", bus_a.ir_write, 1'b0);
        check("fetch_stall_pc", bus_a.pc_write, 1'b0);
        step();
        check("fetch_stall_state", bus_a.state_dbg, ST_FETCH);
        mem_ready = 1'b1;
        #1;
        check("fetch_ready_ir", bus_a.ir_write, 1'b1);

        // jal: FETCH, DECODE, JAL, ALUWB
        set_instr(OPC_JAL, 3'b000, 1'b0);
        step();
        step();
        check("jal_state",    bus_a.state_dbg, ST_JAL);
        check("jal_pc_write", bus_a.pc_write,  1'b1);
        check("jal_src_a",    bus_a.alu_src_a, 2'b01);
        step();
        check("jal_wb_state", bus_a.state_dbg, ST_ALUWB);
        check("jal_wb_regwr", bus_a.reg_write, 1'b1);
        step();

        // Reset while a store is waiting in MEMWRITE
        set_instr(OPC_STORE, 3'b010, 1'b0);
        step();
        step();
        step();
        mem_ready = 1'b0;
        #1;
        check("rstmw_pre_state", bus_a.state_dbg, ST_MEMWRITE);
        check("rstmw_pre_mw",    bus_a.mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmw_mem_write", bus_a.mem_write, 1'b0);
        check("rstmw_state",     bus_a.state_dbg, ST_FETCH);
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rstmw_rel_state",   bus_a.state_dbg, ST_FETCH);
        check("rstmw_rel_illegal", bus_a.illegal,   1'b0);
        check("rstmw_base_illeg",  bus_b.illegal,   1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
